// File: rtl/nfa_pkg.sv
// nfa_pkg: shared config layout for the NFA match engine.
// Per-state word: [7:0] lo, [15:8] hi, [16] nocase, [17] loop, [18] opt, [19] accept.
package nfa_pkg;
    localparam int CFG_W      = 20;
    localparam int LO_LSB     = 0;
    localparam int HI_LSB     = 8;
    localparam int NOCASE_BIT = 16;
    localparam int LOOP_BIT   = 17;
    localparam int OPT_BIT    = 18;
    localparam int ACCEPT_BIT = 19;
    localparam int ANCHOR_BIT = 0;

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5a) || (c >= 8'h61 && c <= 8'h7a);
    endfunction
endpackage

// File: rtl/nfa_class_match.sv
// nfa_class_match: byte range test for one NFA state.
// With nocase, letters also try the opposite case; lo > hi never hits.
module nfa_class_match
    import nfa_pkg::*;
(
    input  logic [7:0] i_lo,
    input  logic [7:0] i_hi,
    input  logic       i_nocase,
    input  logic [7:0] i_char,
    output logic       o_hit
);
    logic [7:0] w_alt;
    logic       w_raw, w_fold;

    assign w_alt  = i_char ^ 8'h20;
    assign w_raw  = (i_char >= i_lo) && (i_char <= i_hi);
    assign w_fold = i_nocase && is_letter(i_char) && (w_alt >= i_lo) && (w_alt <= i_hi);
    assign o_hit  = w_raw | w_fold;
endmodule

// File: rtl/nfa_match_engine.sv
// nfa_match_engine: streaming byte NFA with sticky match and a ready/valid match report.
// States chain in order; opt states may be skipped, loop states re-arm themselves.
module nfa_match_engine
    import nfa_pkg::*;
#(
    parameter int NUM_STATES = 8,
    parameter int CNT_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sod,
    input  logic                            en,
    input  logic [7:0]                      char,
    input  logic                            cfg_we,
    input  logic [$clog2(NUM_STATES+1)-1:0] cfg_addr,
    input  logic [CFG_W-1:0]                cfg_data,
    output logic                            match,
    output logic                            match_valid,
    input  logic                            match_ready,
    output logic [CNT_W-1:0]                match_off,
    output logic                            overflow
);
    localparam int AW = $clog2(NUM_STATES + 1);
    localparam int IW = $clog2(NUM_STATES);

    logic [NUM_STATES-1:0][7:0] r_lo, r_hi;
    logic [NUM_STATES-1:0]      r_nocase, r_loop, r_opt, r_accept, r_active;
    logic                       r_anchored, r_first, r_match, r_valid, r_ovf;
    logic [CNT_W-1:0]           r_cnt, r_off;
    logic [NUM_STATES-1:0]      w_hit, w_in, w_next;
    logic                       w_start, w_hit_now;
    logic [IW-1:0]              w_idx;

    assign w_start = ~r_anchored | r_first;
    assign w_idx   = cfg_addr[IW-1:0];

    genvar g;
    for (g = 0; g < NUM_STATES; g++) begin : g_cls
        nfa_class_match u_cls (
            .i_lo     (r_lo[g]),
            .i_hi     (r_hi[g]),
            .i_nocase (r_nocase[g]),
            .i_char   (char),
            .o_hit    (w_hit[g])
        );
    end

    // The chained entry excludes the self-loop term: a loop only re-arms its own state.
    always_comb begin
        logic v;
        v = w_start;
        for (int i = 0; i < NUM_STATES; i++) begin
            w_in[i] = v;
            v = r_active[i] | (r_opt[i] & v);
        end
    end

    assign w_next    = w_hit & (w_in | (r_loop & r_active));
    assign w_hit_now = |(w_next & r_accept);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo       <= '0;
            r_hi       <= '0;
            r_nocase   <= '0;
            r_loop     <= '0;
            r_opt      <= '0;
            r_accept   <= '0;
            r_anchored <= 1'b0;
            r_active   <= '0;
            r_first    <= 1'b1;
            r_cnt      <= '0;
            r_match    <= 1'b0;
            r_valid    <= 1'b0;
            r_off      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (r_valid && match_ready) r_valid <= 1'b0;
            if (sod) begin
                r_active <= '0;
                r_first  <= 1'b1;
                r_cnt    <= '0;
                r_match  <= 1'b0;
                r_ovf    <= 1'b0;
            end else if (en) begin
                r_active <= w_next;
                r_first  <= 1'b0;
                if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                if (w_hit_now) begin
                    r_match <= 1'b1;
                    if (!r_valid || match_ready) begin
                        r_valid <= 1'b1;
                        r_off   <= r_cnt;
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end
            end
            if (cfg_we) begin
                if (cfg_addr == AW'(NUM_STATES)) begin
                    r_anchored <= cfg_data[ANCHOR_BIT];
                end else if (cfg_addr < AW'(NUM_STATES)) begin
                    r_lo[w_idx]     <= cfg_data[LO_LSB +: 8];
                    r_hi[w_idx]     <= cfg_data[HI_LSB +: 8];
                    r_nocase[w_idx] <= cfg_data[NOCASE_BIT];
                    r_loop[w_idx]   <= cfg_data[LOOP_BIT];
                    r_opt[w_idx]    <= cfg_data[OPT_BIT];
                    r_accept[w_idx] <= cfg_data[ACCEPT_BIT];
                end
            end
        end
    end

    assign match       = r_match;
    assign match_valid = r_valid;
    assign match_off   = r_off;
    assign overflow    = r_ovf;
endmodule
